// File: rtl/bit_serial_adder.sv
// Bit-serial ripple adder: one full-adder cell (two half adders plus an OR)
// consumes one operand bit pair per clock, LSB first, between two valid/ready handshakes.

module half_adder (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;

    logic w_ha0_s;
    logic w_ha0_c;
    logic w_ha1_c;
    logic w_s;
    logic w_c;

    // Full-adder cell: first half adder on the operand bits, second folds in the carry.
    half_adder u_ha0 (
        .i_x (r_a_sh[0]),
        .i_y (r_b_sh[0]),
        .o_s (w_ha0_s),
        .o_c (w_ha0_c)
    );

    half_adder u_ha1 (
        .i_x (w_ha0_s),
        .i_y (r_carry),
        .o_s (w_s),
        .o_c (w_ha1_c)
    );

    assign w_c = w_ha0_c | w_ha1_c;

    // in_ready is gated by rst combinationally so a request is never accepted on a reset edge.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign busy      = (r_state == S_RUN);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum_sh;
    assign cout      = r_cout;

    // NOTE: every register here is written with <= so all flops see the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_carry  <= cin;
                        r_cnt    <= '0;
                        r_sum_sh <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry  <= w_c;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        r_cout  <= w_c;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed cases plus a randomized run,
// compared every cycle against a transaction-level arithmetic model.

module tb_bit_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_vec  = 0;
    int n_miss = 0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an operation is "pending" for W cycles, then its arithmetic result is presented.
    int           m_mode = 0;   // 0 idle, 1 computing, 2 presenting
    int           m_left = 0;
    logic [W:0]   m_pend = '0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    bit           m_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1'b1;
            m_mode = 0;
            m_left = 0;
            m_sum  = '0;
            m_cout = 1'b0;
        end else begin
            case (m_mode)
                0: if (in_valid) begin
                    m_pend = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
                    m_left = W;
                    m_mode = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = 2;
                        m_sum  = m_pend[W-1:0];
                        m_cout = m_pend[W];
                    end
                end
                default: if (out_ready) m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("m_in_ready",  32'(in_ready),  32'(m_mode == 0 && !rst));
            check("m_busy",      32'(busy),      32'(m_mode == 1));
            check("m_out_valid", 32'(out_valid), 32'(m_mode == 2));
            if (m_mode != 1) begin
                check("m_sum",  32'(sum),  32'(m_sum));
                check("m_cout", 32'(cout), 32'(m_cout));
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        in_valid = 1'b1;
        a = ta;
        b = tb;
        cin = tc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [W-1:0] s, output logic c, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
            if (busy) bc++;
        end
        if (!out_valid) check("result_timeout", 32'(out_valid), 32'd1);
        s = sum;
        c = cout;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_case(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tc, input logic [W-1:0] es, input logic ec);
        logic [W-1:0] s;
        logic         c;
        int           lat;
        int           bc;
        send(ta, tb, tc);
        wait_result(s, c, lat, bc);
        check({name, "_sum"},  32'(s),  32'(es));
        check({name, "_cout"}, 32'(c),  32'(ec));
        check({name, "_lat"},  32'(lat), 32'(W));
        check({name, "_busy"}, 32'(bc),  32'(W));
        take();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] s;
        logic         c;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   ref_sum;
        int           lat;
        int           bc;
        bit           saw_ov;

        // Reset held two cycles with a request pending.
        rst = 1'b1;
        in_valid = 1'b1;
        a = 8'hAA;
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready",  32'(in_ready),  32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_busy",      32'(busy),      32'd0);
        check("post_rst_sum",       32'(sum),       32'h00);
        check("post_rst_cout",      32'(cout),      32'd0);
        repeat (3) @(negedge clk);
        check("no_accept_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        run_case("basic",  8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
        run_case("carry1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_case("carry2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_case("cinonly", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

        // Backpressure: result must hold steady while out_ready stays low.
        send(8'h5A, 8'h3B, 1'b1);
        wait_result(s, c, lat, bc);
        check("bp_sum", 32'(s), 32'h96);
        check("bp_cout", 32'(c), 32'd0);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_ov",  32'(out_valid), 32'd1);
            check("bp_hold_sum", 32'(sum),       32'(s));
            check("bp_hold_cout", 32'(cout),     32'(c));
            check("bp_in_ready", 32'(in_ready),  32'd0);
        end
        take();
        @(negedge clk);
        check("bp_after_in_ready", 32'(in_ready),  32'd1);
        check("bp_after_ov",       32'(out_valid), 32'd0);
        check("bp_after_sum",      32'(sum),       32'h96);
        @(posedge clk);
        #1;

        // Interference: a request raised mid-run waits and is taken in the first idle cycle.
        send(8'h3C, 8'h05, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'h11;
        b = 8'h22;
        cin = 1'b0;
        wait_result(s, c, lat, bc);
        check("intf_first_sum", 32'(s), 32'h41);
        check("intf_first_cout", 32'(c), 32'd0);
        take();
        send(8'h11, 8'h22, 1'b0);
        wait_result(s, c, lat, bc);
        check("intf_second_sum", 32'(s), 32'h33);
        check("intf_second_lat", 32'(lat), 32'(W));
        take();

        // Reset on the third RUN cycle abandons the operation.
        send(8'h77, 8'h88, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        saw_ov = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (out_valid) saw_ov = 1'b1;
        end
        check("midrst_no_ov", 32'(saw_ov), 32'd0);
        check("midrst_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        run_case("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

        // Randomized run, with early out_ready and variable stalls on both sides.
        for (int n = 0; n < 500; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            ref_sum = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(ra, rb, rc);
            if ($urandom_range(0, 3) == 0) out_ready = 1'b1;
            wait_result(s, c, lat, bc);
            check("rnd_sum",  32'(s),   32'(ref_sum[W-1:0]));
            check("rnd_cout", 32'(c),   32'(ref_sum[W]));
            check("rnd_lat",  32'(lat), 32'(W));
            if (!out_ready) repeat ($urandom_range(0, 2)) @(negedge clk);
            take();
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Bit-serial ripple adder built around the team's half-adder stage.
- Two half-adder cells plus an OR form one full-adder cell, driven with one bit pair per clock, LSB first.
- Accepts a WIDTH-bit operand pair over a valid/ready handshake and adds serially over WIDTH cycles.
- Presents the WIDTH-bit sum and carry-out over a second valid/ready handshake; feeds the downstream tt_um_* wrapper's output pins.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high; sampled on rising edge of clk.
- in_valid  input  1  operand pair on a/b/cin is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for the LSB.
- out_valid  output  1  sum/cout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result bits, (a+b+cin) mod 2^WIDTH.
- cout  output  1  carry out of MSB.
- busy  output  1  high while a serial addition is in progress (RUN state).

Behaviour:
- Reset (rst=1 at an edge): state←IDLE, a_sh/b_sh/sum_sh←0, carry←0, cnt←0, out_valid←0, cout←0.
  - in_ready is forced 0 in any cycle where rst=1; in_valid is ignored.
  - After reset: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- States: IDLE, RUN, DONE (2-bit encoding).
  - in_ready=1 only in IDLE with rst=0.
  - busy=1 only in RUN.
  - out_valid=1 only in DONE.
- IDLE:
  - On in_valid&in_ready: a_sh←a, b_sh←b, carry←cin, cnt←0, sum_sh←0, go RUN.
  - Otherwise stay IDLE.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^carry; c = (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0])).
  - sum_sh←{s, sum_sh[WIDTH-1:1]}; a_sh, b_sh shift right 1 with 0 fill; carry←c; cnt←cnt+1.
  - When cnt==WIDTH-1 at the edge: go DONE and cout←c.
  - Exactly WIDTH RUN edges per operation.
- DONE:
  - sum=sum_sh and cout stay stable while out_valid=1 and out_ready=0; no timeout.
  - On out_valid&out_ready: go IDLE; out_valid=0 next cycle.
- Latency and throughput:
  - Accept edge at T → out_valid first high in the cycle after edge T+WIDTH, i.e. WIDTH cycles after acceptance.
  - Minimum initiation interval is WIDTH+2 cycles: no accept in the same cycle as the result handshake.
- Arithmetic: sum modulo 2^WIDTH; cout is the true carry; a+b+cin ≤ 2^(WIDTH+1)-1, so there is no other overflow.
- sum/cout outside DONE:
  - After a result handshake, sum/cout retain the last result until the next accept.
  - sum toggles during RUN; consumers only sample sum/cout when out_valid=1.
- cnt width is clog2(WIDTH)+1 and never wraps within an operation.
- Boundary conditions:
  - in_valid during RUN/DONE: ignored, no effect on the in-flight result.
  - in_valid held through DONE→IDLE: accepted in the first IDLE cycle.
  - out_ready high before DONE: no effect.
  - rst mid-RUN or in DONE: operation abandoned; IDLE next cycle; out_valid never pulses for it.
  - rst takes priority over every handshake in the same cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, a=0xAA → in_ready=0 throughout; after release in_ready=1, out_valid=0, busy=0, sum=0x00, cout=0; nothing accepted.
- Basic add, WIDTH=8: a=0x3C, b=0x05, cin=0 → sum=0x41, cout=0; out_valid rises exactly 8 cycles after the accept edge; busy high for exactly 8 cycles.
- Carry cases:
  - a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
  - a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid, sum, cout constant and in_ready=0; out_ready=1 → IDLE next cycle, in_ready=1, sum still holds the result.
- Interference: a new in_valid with a=0x11, b=0x22 during RUN of 0x3C+0x05 → ignored, result 0x41; the held request is then accepted and gives 0x33.
- Reset mid-operation: rst=1 on the 3rd RUN cycle → IDLE next cycle; out_valid never asserts; the following 0x10+0x20 gives 0x30, cout=0; randomized 500-vector run matches the a+b+cin reference model.
